// File: rtl/key_evt_pkg.sv
// -----------------------------------------------------------------------------
// key_evt_pkg
// Shared definitions for the key event controller: event type encodings,
// classifier FSM state encodings, default timing parameters and a helper
// that sizes the per-key timing counter.
// -----------------------------------------------------------------------------
package key_evt_pkg;

    localparam int NUM_KEYS = 4;
    localparam int ID_W     = 2;

    // 1 s and 300 ms at a 50 MHz system clock
    localparam int LONG_CNT_DEFAULT = 50_000_000;
    localparam int DBL_WIN_DEFAULT  = 15_000_000;

    // EVT_NONE is never presented on the output; it marks "no type" internally
    typedef enum logic [1:0] {
        EVT_NONE   = 2'b00,
        EVT_SINGLE = 2'b01,
        EVT_DOUBLE = 2'b10,
        EVT_LONG   = 2'b11
    } evt_type_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS1    = 3'd1,
        ST_WAIT2     = 3'd2,
        ST_PRESS2    = 3'd3,
        ST_LONG_HELD = 3'd4
    } key_fsm_state_e;

    // Counter width able to hold the larger of the two timing limits
    function automatic int cnt_width(input int long_cnt, input int dbl_win);
        int span;
        span = (long_cnt > dbl_win) ? long_cnt : dbl_win;
        return (span < 2) ? 1 : $clog2(span + 1);
    endfunction

endpackage

// File: rtl/key_evt_ctrl_if.sv
// -----------------------------------------------------------------------------
// key_evt_ctrl_if
// Valid/ready event stream from the key event controller to its consumer.
//   evt_valid : event available on evt_id / evt_type
//   evt_ready : consumer accepts when evt_valid && evt_ready at posedge Clk
//   evt_id    : index of the key that produced the event
//   evt_type  : single / double / long
//   evt_ovf   : one-cycle pulse, an unread pending event was overwritten
// master = controller side, slave = consumer side.
// -----------------------------------------------------------------------------
interface key_evt_ctrl_if;
    import key_evt_pkg::*;

    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    evt_type_e       evt_type;
    logic            evt_ovf;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_type,
        output evt_ovf,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_type,
        input  evt_ovf,
        output evt_ready
    );

endinterface

// File: rtl/key_evt_fsm.sv
// -----------------------------------------------------------------------------
// key_evt_fsm
// Per-key click classifier. Watches one key's debounced edge pulse and level
// and emits a registered one-cycle pulse with the classified event type.
//   Clk, Reset_n : system clock, asynchronous active-low reset
//   key_flag     : one-cycle debounced edge pulse
//   key_state    : debounced level, 0 = pressed, 1 = released
//   emit         : one-cycle pulse, an event was classified
//   emit_type    : type of the classified event, valid with emit
// -----------------------------------------------------------------------------
module key_evt_fsm
    import key_evt_pkg::*;
#(
    parameter int LONG_CNT = LONG_CNT_DEFAULT,
    parameter int DBL_WIN  = DBL_WIN_DEFAULT
) (
    input  logic      Clk,
    input  logic      Reset_n,
    input  logic      key_flag,
    input  logic      key_state,
    output logic      emit,
    output evt_type_e emit_type
);

    localparam int               CNT_W     = cnt_width(LONG_CNT, DBL_WIN);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_WIN - 1);

    key_fsm_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             emit_d;
    evt_type_e        emit_type_d;
    logic             press;
    logic             rel;

    assign press = key_flag & ~key_state;
    assign rel   = key_flag &  key_state;

    // State, counter and the registered emission pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            emit      <= 1'b0;
            emit_type <= EVT_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            emit      <= emit_d;
            emit_type <= emit_type_d;
        end
    end

    // Next-state logic. In PRESS1 and WAIT2 the counter reaching its terminal
    // value wins over an edge arriving in the same cycle, so a key edge that
    // lands exactly on the deadline is dropped.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        emit_d      = 1'b0;
        emit_type_d = EVT_NONE;

        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d = ST_PRESS1;
                    cnt_d   = '0;
                end
            end
            ST_PRESS1: begin
                if (cnt_q == LONG_LAST) begin
                    emit_d      = 1'b1;
                    emit_type_d = EVT_LONG;
                    state_d     = ST_LONG_HELD;
                end else if (rel) begin
                    state_d = ST_WAIT2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT2: begin
                if (cnt_q == DBL_LAST) begin
                    emit_d      = 1'b1;
                    emit_type_d = EVT_SINGLE;
                    state_d     = ST_IDLE;
                end else if (press) begin
                    state_d = ST_PRESS2;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // The second press of a double click is never timed for long
            ST_PRESS2: begin
                if (rel) begin
                    emit_d      = 1'b1;
                    emit_type_d = EVT_DOUBLE;
                    state_d     = ST_IDLE;
                end
            end
            // The long event was already reported; just wait for the release
            ST_LONG_HELD: begin
                if (rel) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/key_evt_ctrl.sv
// -----------------------------------------------------------------------------
// key_evt_ctrl
// Classifies presses on four debounced keys into single / double / long
// events and presents them one at a time on a valid/ready stream.
//   Clk, Reset_n : system clock, asynchronous active-low reset
//   key_flag     : per-key one-cycle debounced edge pulse
//   key_state    : per-key debounced level, 0 = pressed, 1 = released
//   evt          : event stream (key_evt_ctrl_if master)
// One key_evt_fsm per key feeds a one-deep pending slot per key; a
// round-robin arbiter moves pending slots into the registered output.
// -----------------------------------------------------------------------------
module key_evt_ctrl
    import key_evt_pkg::*;
#(
    parameter int LONG_CNT = LONG_CNT_DEFAULT,
    parameter int DBL_WIN  = DBL_WIN_DEFAULT
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [NUM_KEYS-1:0] key_flag,
    input  logic [NUM_KEYS-1:0] key_state,
    key_evt_ctrl_if.master      evt
);

    logic [NUM_KEYS-1:0] emit;
    evt_type_e           emit_type   [NUM_KEYS];
    logic [NUM_KEYS-1:0] pend_q;
    evt_type_e           pend_type_q [NUM_KEYS];
    logic                ovf_q;

    logic                valid_q;
    logic [ID_W-1:0]     id_q;
    evt_type_e           type_q;
    logic [ID_W-1:0]     ptr_q;

    logic                load_en;
    logic                grant_vld;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     scan_idx;
    logic [NUM_KEYS-1:0] grant_oh;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_evt_fsm #(
            .LONG_CNT (LONG_CNT),
            .DBL_WIN  (DBL_WIN)
        ) u_fsm (
            .Clk       (Clk),
            .Reset_n   (Reset_n),
            .key_flag  (key_flag[g]),
            .key_state (key_state[g]),
            .emit      (emit[g]),
            .emit_type (emit_type[g])
        );
    end

    // The output register may take a new event when it is empty or when its
    // current event is being accepted this very cycle (back-to-back).
    assign load_en = !valid_q || evt.evt_ready;

    // Round-robin pick: first pending key at or after the pointer, wrapping
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        scan_idx  = ptr_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            scan_idx = ptr_q + ID_W'(k);
            if (!grant_vld && pend_q[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign grant_oh = (load_en && grant_vld) ? (NUM_KEYS'(1) << grant_idx) : '0;

    // Pending slots. A new emission always wins, so a slot granted in the same
    // cycle stays set with the fresh type. Only an emission landing on a slot
    // that is still full after this cycle counts as an overflow.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                pend_type_q[i] <= EVT_NONE;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (emit[i]) begin
                    pend_q[i]      <= 1'b1;
                    pend_type_q[i] <= emit_type[i];
                end else if (grant_oh[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
            ovf_q <= |(emit & pend_q & ~grant_oh);
        end
    end

    // Output register and round-robin pointer; contents only change on a load,
    // which keeps them stable while the consumer stalls.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            type_q  <= EVT_NONE;
            ptr_q   <= '0;
        end else if (load_en) begin
            if (grant_vld) begin
                valid_q <= 1'b1;
                id_q    <= grant_idx;
                type_q  <= pend_type_q[grant_idx];
                ptr_q   <= grant_idx + ID_W'(1);
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_id    = id_q;
    assign evt.evt_type  = type_q;
    assign evt.evt_ovf   = ovf_q;

endmodule

// File: tb/tb_key_evt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_evt_ctrl
// Self-checking bench for key_evt_ctrl with LONG_CNT=100, DBL_WIN=40.
// A table of single-key click scenarios with hand-computed latency, id and
// type, plus hand-written sequences for arbitration, overflow and reset.
// -----------------------------------------------------------------------------
module tb_key_evt_ctrl;

    localparam int LONG_CNT = 100;
    localparam int DBL_WIN  = 40;
    localparam int CLK_HALF = 5;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [3:0] key_flag;
    logic [3:0] key_state;

    key_evt_ctrl_if evt_if ();

    key_evt_ctrl #(
        .LONG_CNT (LONG_CNT),
        .DBL_WIN  (DBL_WIN)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .key_flag  (key_flag),
        .key_state (key_state),
        .evt       (evt_if)
    );

    always #CLK_HALF Clk = ~Clk;

    // ref_sel: 0 = latency from the first press, 1 = from the first release,
    // 2 = from the second release. gap < 0 means no second press.
    typedef struct {
        string      name;
        int         key;
        int         hold1;
        int         gap;
        int         hold2;
        int         ref_sel;
        logic [1:0] exp_type;
        int         exp_lat;
    } vec_t;

    vec_t vecs [9];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit seen;
    int seen_cyc;
    int seen_id;
    int seen_type;
    int ovf_cnt;

    // One clock step; samples outputs 1 ns after the edge and records the
    // first event shown and every overflow pulse.
    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
        if (evt_if.evt_valid && !seen) begin
            seen      = 1'b1;
            seen_cyc  = cyc;
            seen_id   = int'(evt_if.evt_id);
            seen_type = int'(evt_if.evt_type);
        end
        if (evt_if.evt_ovf) ovf_cnt++;
    endtask

    task automatic clearSeen();
        seen      = 1'b0;
        seen_cyc  = -1;
        seen_id   = -1;
        seen_type = -1;
    endtask

    task automatic pressKeys(input logic [3:0] mask);
        key_state = key_state & ~mask;
        key_flag  = mask;
        tick();
        key_flag  = 4'b0000;
    endtask

    task automatic releaseKeys(input logic [3:0] mask);
        key_state = key_state | mask;
        key_flag  = mask;
        tick();
        key_flag  = 4'b0000;
    endtask

    task automatic acceptOne();
        evt_if.evt_ready = 1'b1;
        tick();
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic waitSeen(input int bound);
        int n;
        n = 0;
        while (!seen && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int seenLat(input int ref_cyc);
        return seen ? (seen_cyc - ref_cyc) : -1;
    endfunction

    function automatic int shownId();
        return evt_if.evt_valid ? int'(evt_if.evt_id) : -1;
    endfunction

    task automatic applyStimulus(input vec_t v, output int r0, output int r1, output int r2);
        logic [3:0] m;
        m = 4'b0001 << v.key;
        clearSeen();
        pressKeys(m);
        r0 = cyc;
        repeat (v.hold1) tick();
        releaseKeys(m);
        r1 = cyc;
        r2 = cyc;
        if (v.gap >= 0) begin
            repeat (v.gap) tick();
            pressKeys(m);
            repeat (v.hold2) tick();
            releaseKeys(m);
            r2 = cyc;
        end
        repeat (60) tick();
    endtask

    initial begin
        #1_000_000;
        mismatched++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        int r0, r1, r2, r, p, ref_cyc;

        vecs[0] = '{name:"single_k0",      key:0, hold1:10,  gap:-1, hold2:0,   ref_sel:1, exp_type:2'b01, exp_lat:42};
        vecs[1] = '{name:"double_k1",      key:1, hold1:5,   gap:20, hold2:5,   ref_sel:2, exp_type:2'b10, exp_lat:2};
        vecs[2] = '{name:"long_k2",        key:2, hold1:150, gap:-1, hold2:0,   ref_sel:0, exp_type:2'b11, exp_lat:102};
        vecs[3] = '{name:"single_k3",      key:3, hold1:3,   gap:-1, hold2:0,   ref_sel:1, exp_type:2'b01, exp_lat:42};
        vecs[4] = '{name:"dbl_gap38_k3",   key:3, hold1:4,   gap:38, hold2:2,   ref_sel:2, exp_type:2'b10, exp_lat:2};
        vecs[5] = '{name:"dbl_gap39_k1",   key:1, hold1:4,   gap:39, hold2:2,   ref_sel:1, exp_type:2'b01, exp_lat:42};
        vecs[6] = '{name:"hold98_k0",      key:0, hold1:98,  gap:-1, hold2:0,   ref_sel:1, exp_type:2'b01, exp_lat:42};
        vecs[7] = '{name:"hold99_k2",      key:2, hold1:99,  gap:-1, hold2:0,   ref_sel:0, exp_type:2'b11, exp_lat:102};
        vecs[8] = '{name:"press2_long_k0", key:0, hold1:5,   gap:10, hold2:150, ref_sel:2, exp_type:2'b10, exp_lat:2};

        Reset_n          = 1'b0;
        key_flag         = 4'b0000;
        key_state        = 4'b1111;
        evt_if.evt_ready = 1'b0;
        clearSeen();
        ovf_cnt = 0;

        // Reset values
        #12;
        checkOutput("rst_valid", int'(evt_if.evt_valid), 0);
        checkOutput("rst_id",    int'(evt_if.evt_id),    0);
        checkOutput("rst_type",  int'(evt_if.evt_type),  0);
        checkOutput("rst_ovf",   int'(evt_if.evt_ovf),   0);
        Reset_n = 1'b1;
        repeat (2) tick();

        // Arbitration: keys 1 and 3 emit together, consumer stalls 5 cycles
        clearSeen();
        ovf_cnt = 0;
        pressKeys(4'b1010);
        repeat (5) tick();
        releaseKeys(4'b1010);
        r = cyc;
        waitSeen(60);
        checkOutput("arb_lat",   seenLat(r), 42);
        checkOutput("arb_id1",   seen_id,    1);
        checkOutput("arb_type1", seen_type,  1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("arb_hold_id", shownId(), 1);
        end
        acceptOne();
        checkOutput("arb_b2b_id",   shownId(),               3);
        checkOutput("arb_b2b_type", int'(evt_if.evt_type),   1);
        acceptOne();
        checkOutput("arb_empty",    int'(evt_if.evt_valid),  0);
        checkOutput("arb_no_ovf",   ovf_cnt,                 0);

        // Overflow: key0 holds the output, key2 single then long overwrites.
        // Key0 being granted first also shows the pointer wrapped back to 0.
        clearSeen();
        ovf_cnt = 0;
        pressKeys(4'b0101);
        repeat (5) tick();
        releaseKeys(4'b0101);
        r = cyc;
        waitSeen(60);
        checkOutput("ovf_first_lat", seenLat(r), 42);
        checkOutput("ovf_first_id",  seen_id,    0);
        repeat (3) tick();
        pressKeys(4'b0100);
        p = cyc;
        repeat (110) tick();
        releaseKeys(4'b0100);
        repeat (5) tick();
        checkOutput("ovf_pulses",    ovf_cnt,               1);
        checkOutput("ovf_held_id",   shownId(),             0);
        acceptOne();
        checkOutput("ovf_k2_id",     shownId(),             2);
        checkOutput("ovf_k2_type",   int'(evt_if.evt_type), 3);
        acceptOne();
        checkOutput("ovf_empty",     int'(evt_if.evt_valid), 0);

        // Table-driven single-key scenarios
        ovf_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], r0, r1, r2);
            ref_cyc = (vecs[i].ref_sel == 0) ? r0 : ((vecs[i].ref_sel == 1) ? r1 : r2);
            checkOutput({vecs[i].name, "_lat"},  seenLat(ref_cyc), vecs[i].exp_lat);
            checkOutput({vecs[i].name, "_id"},   seen_id,          vecs[i].key);
            checkOutput({vecs[i].name, "_type"}, seen_type,        int'(vecs[i].exp_type));
            acceptOne();
            checkOutput({vecs[i].name, "_only_one"}, int'(evt_if.evt_valid), 0);
        end
        checkOutput("table_no_ovf", ovf_cnt, 0);

        // Reset with an event shown, key3 event delivered and key0 mid-PRESS1
        clearSeen();
        pressKeys(4'b1000);
        repeat (3) tick();
        releaseKeys(4'b1000);
        repeat (10) tick();
        pressKeys(4'b0001);
        repeat (40) tick();
        checkOutput("prerst_id", shownId(), 3);
        #1;
        Reset_n = 1'b0;
        #2;
        checkOutput("midrst_valid", int'(evt_if.evt_valid), 0);
        checkOutput("midrst_id",    int'(evt_if.evt_id),    0);
        checkOutput("midrst_type",  int'(evt_if.evt_type),  0);
        checkOutput("midrst_ovf",   int'(evt_if.evt_ovf),   0);
        #2;
        Reset_n = 1'b1;
        clearSeen();
        tick();
        releaseKeys(4'b0001);
        repeat (150) tick();
        checkOutput("postrst_no_event", int'(seen), 0);
        checkOutput("postrst_valid",    int'(evt_if.evt_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
